select_game_sm: RTL and testbench



---
 rtl/select_game_sm.sv | 144 ++++++++++++++
 tb/tb_select_game_sm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/select_game_sm.sv
// Game-mode selector: synchronises sw[1:0], optionally debounces them, and drives
// registered one-hot screen-select flags. Optional filter: SELECT_GAME_DEBOUNCE_EN.
module select_game_sm #(
   parameter int DEBOUNCE_CYCLES = 650_000,
   parameter int SYNC_STAGES     = 2
) (
   input  logic        clk65MHz,
   input  logic        rst,
   input  logic [15:0] sw,
   output logic        screen_idle,
   output logic        screen_single,
   output logic        screen_multi
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SINGLE = 2'b01,
      ST_MULTI  = 2'b10
   } state_t;

   logic [1:0] sync_r [SYNC_STAGES];
   logic [1:0] sel_sync_s;
   logic [1:0] sel_stable_s;
   state_t     state_r;
   state_t     state_next_s;
   logic       idle_next_s;
   logic       single_next_s;
   logic       multi_next_s;
   logic       unused_sw_s;

   // Upper switches are deliberately not connected to any logic.
   assign unused_sw_s = ^sw[15:2];

   // Synchroniser chain for the two mode switches.
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= 2'b00;
         end
      end else begin
         sync_r[0] <= sw[1:0];
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   assign sel_sync_s = sync_r[SYNC_STAGES-1];

`ifdef SELECT_GAME_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] deb_cnt_r;
   logic [CNT_W-1:0] deb_eff_s;
   logic [1:0]       sel_prev_r;
   logic [1:0]       sel_stable_r;

   // A fresh change of the synced pair restarts the count at zero.
   always_comb begin
      deb_eff_s = deb_cnt_r;
      if (sel_sync_s != sel_prev_r) begin
         deb_eff_s = {CNT_W{1'b0}};
      end else begin
         deb_eff_s = deb_cnt_r;
      end
   end

   // Debounce counter and accepted switch value.
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         deb_cnt_r    <= {CNT_W{1'b0}};
         sel_prev_r   <= 2'b00;
         sel_stable_r <= 2'b00;
      end else begin
         sel_prev_r <= sel_sync_s;
         if (sel_sync_s == sel_stable_r) begin
            deb_cnt_r <= {CNT_W{1'b0}};
         end else if (deb_eff_s == CNT_LAST) begin
            sel_stable_r <= sel_sync_s;
            deb_cnt_r    <= {CNT_W{1'b0}};
         end else begin
            deb_cnt_r <= deb_eff_s + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign sel_stable_s = sel_stable_r;
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   assign sel_stable_s = sel_sync_s;
`endif

   // Next state depends only on the accepted switch pair, from any state.
   always_comb begin
      state_next_s = ST_IDLE;
      case (sel_stable_s)
         2'b01:   state_next_s = ST_SINGLE;
         2'b10:   state_next_s = ST_MULTI;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // One-hot decode of the next state; unknown encodings fall back to idle.
   always_comb begin
      idle_next_s   = 1'b1;
      single_next_s = 1'b0;
      multi_next_s  = 1'b0;
      case (state_next_s)
         ST_SINGLE: begin
            idle_next_s   = 1'b0;
            single_next_s = 1'b1;
            multi_next_s  = 1'b0;
         end
         ST_MULTI: begin
            idle_next_s   = 1'b0;
            single_next_s = 1'b0;
            multi_next_s  = 1'b1;
         end
         default: begin
            idle_next_s   = 1'b1;
            single_next_s = 1'b0;
            multi_next_s  = 1'b0;
         end
      endcase
   end

   // State and output flags update together so outputs always match the state.
   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         screen_idle   <= 1'b1;
         screen_single <= 1'b0;
         screen_multi  <= 1'b0;
      end else begin
         state_r       <= state_next_s;
         screen_idle   <= idle_next_s;
         screen_single <= single_next_s;
         screen_multi  <= multi_next_s;
      end
   end

endmodule

// File: tb/tb_select_game_sm.sv
// Directed bench for select_game_sm: expected flags are hand-computed per step,
// plus a continuous one-hot check on every falling edge.
`timescale 1ns/1ps
module tb_select_game_sm;

   logic        clk65MHz;
   logic        rst;
   logic [15:0] sw;
   logic        screen_idle;
   logic        screen_single;
   logic        screen_multi;

   int checks = 0;
   int errors = 0;
   bit onehot_en = 1'b0;

   localparam logic [2:0] EXP_IDLE   = 3'b100;
   localparam logic [2:0] EXP_SINGLE = 3'b010;
   localparam logic [2:0] EXP_MULTI  = 3'b001;

   select_game_sm #(
      .DEBOUNCE_CYCLES(4),
      .SYNC_STAGES    (2)
   ) dut (
      .clk65MHz     (clk65MHz),
      .rst          (rst),
      .sw           (sw),
      .screen_idle  (screen_idle),
      .screen_single(screen_single),
      .screen_multi (screen_multi)
   );

   initial clk65MHz = 1'b0;
   always #8 clk65MHz = ~clk65MHz;

   // Continuous one-hot check away from the active edge.
   always @(negedge clk65MHz) begin
      if (onehot_en) begin
         checks++;
         assert ($onehot({screen_idle, screen_single, screen_multi}))
         else begin
            errors++;
            $error("FAIL onehot: observed=%b required=exactly one bit high",
                   {screen_idle, screen_single, screen_multi});
         end
      end
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk65MHz);
      end
      #1;
   endtask

   task automatic check3(input string tag, input logic [2:0] expv);
      logic [2:0] obs;
      obs = {screen_idle, screen_single, screen_multi};
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s: observed={idle,single,multi}=%b expected=%b", tag, obs, expv);
      end
   endtask

   initial begin
      rst = 1'b1;
      sw  = 16'h0003;
      tick(1);
      onehot_en = 1'b1;
      check3("reset_cycle1", EXP_IDLE);
      tick(1);
      check3("reset_cycle2", EXP_IDLE);
      rst = 1'b0;
      tick(1);
      check3("post_reset_1", EXP_IDLE);
      tick(2);
      check3("post_reset_3_sw11", EXP_IDLE);

`ifndef SELECT_GAME_DEBOUNCE_EN
      sw = 16'h0001;
      tick(2);
      check3("single_not_yet", EXP_IDLE);
      tick(1);
      check3("single", EXP_SINGLE);

      sw = 16'h0002;
      tick(1);
      check3("to_multi_edge1", EXP_SINGLE);
      tick(1);
      check3("to_multi_edge2", EXP_SINGLE);
      tick(1);
      check3("multi_direct", EXP_MULTI);
      tick(5);
      check3("multi_hold", EXP_MULTI);

      sw = 16'h0003;
      tick(3);
      check3("sw11_idle", EXP_IDLE);
      sw = 16'h0000;
      tick(3);
      check3("sw00_idle", EXP_IDLE);

      sw = 16'hFFFD;
      tick(3);
      check3("upper_bits_single", EXP_SINGLE);
      sw = 16'h0001;
      tick(3);
      check3("upper_bits_cleared", EXP_SINGLE);
      sw = 16'hFFFE;
      tick(3);
      check3("upper_bits_multi", EXP_MULTI);
      sw = 16'hFFFC;
      tick(3);
      check3("upper_bits_idle", EXP_IDLE);

      sw = 16'h0001;
      tick(3);
      check3("pre_reset_single", EXP_SINGLE);
      rst = 1'b1;
      tick(1);
      check3("mid_reset_idle", EXP_IDLE);
      rst = 1'b0;
      tick(1);
      check3("after_rst_edge1", EXP_IDLE);
      tick(1);
      check3("after_rst_edge2", EXP_IDLE);
      tick(1);
      check3("after_rst_edge3_single", EXP_SINGLE);
`else
      sw = 16'h0000;
      tick(8);
      check3("deb_base_idle", EXP_IDLE);
      sw = 16'h0001;
      tick(2);
      sw = 16'h0000;
      tick(8);
      check3("deb_pulse_rejected", EXP_IDLE);
      sw = 16'h0001;
      tick(6);
      check3("deb_hold_not_yet", EXP_IDLE);
      tick(1);
      check3("deb_hold_single", EXP_SINGLE);
      tick(3);
      check3("deb_hold_stays", EXP_SINGLE);
`endif

      tick(2);
      onehot_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
